// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle shared by the requesters, the write arbiter and the downstream FIFO.
// The slave modport is the arbiter's view; the master modport is the requester/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic                  fifo_wfull;
    logic [NREQ-1:0]       gnt;
    logic                  fifo_winc;
    logic [WIDTH-1:0]      fifo_wdata;
    logic [OW-1:0]         owner;
    logic                  busy;

    modport master (
        output req, req_data, req_last, fifo_wfull,
        input  gnt, fifo_winc, fifo_wdata, owner, busy
    );

    modport slave (
        input  req, req_data, req_last, fifo_wfull,
        output gnt, fifo_winc, fifo_wdata, owner, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that hands the FIFO write port to one requester at a time,
// holding it for a packet, a burst of up to MAX_BURST beats, or until the owner withdraws.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   rr_ptr;
    logic [CW-1:0]   beat_cnt;
    logic [OW-1:0]   pick;
    logic [OW-1:0]   cand;
    logic            pick_valid;
    logic            busy;
    logic            owner_req;
    logic            owner_last;
    logic            accept;
    logic            release_now;

    // Scan downward so the candidate closest to rr_ptr (wrapping upward) is the last to win.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        cand       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = rr_ptr + OW'(k);
            if (bus.req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    assign busy        = (state == OWN);
    assign owner_req   = bus.req[owner];
    assign owner_last  = bus.req_last[owner];
    assign accept      = busy && owner_req && !bus.fifo_wfull;
    assign release_now = busy && (!owner_req ||
                         (accept && (owner_last || beat_cnt == CW'(MAX_BURST - 1))));

    assign bus.busy       = busy;
    assign bus.owner      = owner;
    assign bus.gnt        = busy ? ({{(NREQ-1){1'b0}}, 1'b1} << owner) : '0;
    assign bus.fifo_winc  = accept;
    assign bus.fifo_wdata = busy ? bus.req_data[owner*WIDTH +: WIDTH] : '0;

    // A stall leaves beat_cnt alone; a pending last beat only releases once it is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner    <= pick;
                        beat_cnt <= '0;
                        state    <= OWN;
                    end
                end
                OWN: begin
                    if (release_now) begin
                        rr_ptr <= owner + OW'(1);
                        state  <= IDLE;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized checks of fifo_wr_arbiter against a tenure-level reference model.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NREQ(N), .WIDTH(W)) bus ();
    fifo_wr_arbiter_if #(.NREQ(N), .WIDTH(W)) bus1 ();

    fifo_wr_arbiter #(.NREQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    fifo_wr_arbiter #(.NREQ(N), .WIDTH(W), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    // Reference model: who holds the port, how many beats they have written, where the search restarts.
    int m_busy  = 0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_beats = 0;

    always @(posedge clk) begin
        int c;
        int found;
        int acc;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
        end else if (m_busy == 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (found == 0 && bus.req[c]) begin
                    m_owner = c; m_busy = 1; m_beats = 0; found = 1;
                end
            end
        end else begin
            acc = (bus.req[m_owner] && !bus.fifo_wfull) ? 1 : 0;
            if (acc == 1) m_beats = m_beats + 1;
            if (!bus.req[m_owner] || (acc == 1 && (bus.req_last[m_owner] || m_beats == MB))) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end
        end
    end

    task automatic clear_inputs();
        bus.req = '0; bus.req_data = '0; bus.req_last = '0; bus.fifo_wfull = 1'b0;
        bus1.req = '0; bus1.req_data = '0; bus1.req_last = '0; bus1.fifo_wfull = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'b1111; bus.req_last = 4'b1111; bus.req_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.gnt, bus.fifo_winc, bus.fifo_wdata, bus.owner} !== {1'b0, 4'b0, 1'b0, 8'h00, 2'd0}) begin
            errors++;
            $display("[TB] FAIL reset_state busy/gnt/winc/wdata/owner got %b/%b/%b/%h/%0d want 0/0000/0/00/0",
                     bus.busy, bus.gnt, bus.fifo_winc, bus.fifo_wdata, bus.owner);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        int ph, own;
        logic eb, ew;
        logic [3:0] eg;
        logic [7:0] ed;
        do_reset();
        for (int t = 0; t < 15; t++) begin
            ph  = t % 3;
            own = (t / 3) % 4;
            bus.req      = 4'b1111;
            bus.req_last = (ph == 2) ? 4'(1 << own) : 4'b0000;
            for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = 8'(i * 16 + t);
            @(negedge clk);
            eb = (ph != 0);
            ew = eb;
            eg = eb ? 4'(1 << own) : 4'b0000;
            ed = eb ? 8'(own * 16 + t) : 8'h00;
            checks++;
            if ({bus.busy, bus.gnt, bus.fifo_winc, bus.fifo_wdata} !== {eb, eg, ew, ed}) begin
                errors++;
                $display("[TB] FAIL round_robin t=%0d busy/gnt/winc/wdata got %b/%b/%b/%h want %b/%b/%b/%h",
                         t, bus.busy, bus.gnt, bus.fifo_winc, bus.fifo_wdata, eb, eg, ew, ed);
            end
            if (eb) begin
                checks++;
                if (bus.owner !== 2'(own)) begin
                    errors++;
                    $display("[TB] FAIL round_robin_owner t=%0d got %0d want %0d", t, bus.owner, own);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_burst_limit();
        logic eb;
        logic [7:0] ed;
        do_reset();
        for (int t = 0; t < 7; t++) begin
            bus.req = 4'b0100;
            bus.req_last = 4'b0000;
            bus.req_data[2*W +: W] = 8'(8'hA0 + t);
            @(negedge clk);
            eb = (t >= 1 && t <= 4) || t == 6;
            ed = eb ? 8'(8'hA0 + t) : 8'h00;
            checks++;
            if ({bus.busy, bus.gnt, bus.fifo_winc, bus.fifo_wdata} !== {eb, (eb ? 4'b0100 : 4'b0000), eb, ed}) begin
                errors++;
                $display("[TB] FAIL burst_limit t=%0d busy/gnt/winc/wdata got %b/%b/%b/%h want %b/%b/%b/%h",
                         t, bus.busy, bus.gnt, bus.fifo_winc, bus.fifo_wdata, eb, (eb ? 4'b0100 : 4'b0000), eb, ed);
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        int sent;
        logic eb, ew;
        logic [7:0] ed;
        sent = 0;
        do_reset();
        for (int t = 0; t < 9; t++) begin
            bus.req = 4'b0010;
            bus.fifo_wfull = (t >= 2 && t <= 4);
            bus.req_data[1*W +: W] = 8'(8'h50 + sent);
            @(negedge clk);
            eb = (t >= 1 && t <= 7);
            ew = eb && !(t >= 2 && t <= 4);
            ed = eb ? 8'(8'h50 + sent) : 8'h00;
            checks++;
            if ({bus.busy, bus.gnt, bus.fifo_winc, bus.fifo_wdata} !== {eb, (eb ? 4'b0010 : 4'b0000), ew, ed}) begin
                errors++;
                $display("[TB] FAIL stall t=%0d busy/gnt/winc/wdata got %b/%b/%b/%h want %b/%b/%b/%h",
                         t, bus.busy, bus.gnt, bus.fifo_winc, bus.fifo_wdata, eb, (eb ? 4'b0010 : 4'b0000), ew, ed);
            end
            if (ew) sent++;
            next_cycle();
        end
        bus.fifo_wfull = 1'b0;
    endtask

    task automatic test_withdraw();
        logic [3:0] rq [5];
        logic [3:0] eg [5];
        logic [7:0] ed [5];
        logic       ew [5];
        rq = '{4'b1000, 4'b1011, 4'b0011, 4'b0011, 4'b0011};
        eg = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        ed = '{8'h00,   8'h31,   8'h32,   8'h00,   8'h04};
        ew = '{1'b0,    1'b1,    1'b0,    1'b0,    1'b1};
        do_reset();
        for (int t = 0; t < 5; t++) begin
            bus.req = rq[t];
            for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = 8'(i * 16 + t);
            @(negedge clk);
            checks++;
            if ({bus.gnt, bus.fifo_winc, bus.fifo_wdata} !== {eg[t], ew[t], ed[t]}) begin
                errors++;
                $display("[TB] FAIL withdraw t=%0d gnt/winc/wdata got %b/%b/%h want %b/%b/%h",
                         t, bus.gnt, bus.fifo_winc, bus.fifo_wdata, eg[t], ew[t], ed[t]);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_tenure();
        do_reset();
        bus.req = 4'b0100;
        bus.req_data = 32'h00_77_00_00;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.fifo_winc, bus.owner} !== {1'b1, 1'b1, 2'd2}) begin
            errors++;
            $display("[TB] FAIL reset_mid_pre busy/winc/owner got %b/%b/%0d want 1/1/2",
                     bus.busy, bus.fifo_winc, bus.owner);
        end
        next_cycle();
        rst = 1'b0;
        bus.req = 4'b1000;
        bus.req_data = 32'h99_77_00_00;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.gnt, bus.fifo_winc, bus.fifo_wdata} !== {1'b0, 4'b0000, 1'b0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL reset_mid_abort busy/gnt/winc/wdata got %b/%b/%b/%h want 0/0000/0/00",
                     bus.busy, bus.gnt, bus.fifo_winc, bus.fifo_wdata);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.owner, bus.gnt, bus.fifo_wdata} !== {1'b1, 2'd3, 4'b1000, 8'h99}) begin
            errors++;
            $display("[TB] FAIL reset_mid_regrant busy/owner/gnt/wdata got %b/%0d/%b/%h want 1/3/1000/99",
                     bus.busy, bus.owner, bus.gnt, bus.fifo_wdata);
        end
        next_cycle();
    endtask

    task automatic test_last_stall();
        int wincs;
        logic eb, ew;
        wincs = 0;
        do_reset();
        for (int t = 0; t < 5; t++) begin
            bus.req        = (t < 4) ? 4'b0001 : 4'b0000;
            bus.req_last   = 4'b0001;
            bus.req_data   = 32'h0000_00E5;
            bus.fifo_wfull = (t == 1 || t == 2);
            @(negedge clk);
            eb = (t >= 1 && t <= 3);
            ew = (t == 3);
            if (bus.fifo_winc === 1'b1) wincs++;
            checks++;
            if ({bus.busy, bus.fifo_winc} !== {eb, ew}) begin
                errors++;
                $display("[TB] FAIL last_stall t=%0d busy/winc got %b/%b want %b/%b", t, bus.busy, bus.fifo_winc, eb, ew);
            end
            next_cycle();
        end
        checks++;
        if (wincs != 1) begin
            errors++;
            $display("[TB] FAIL last_stall_count winc pulses got %0d want 1", wincs);
        end
        bus.fifo_wfull = 1'b0;
    endtask

    task automatic test_max_burst_one();
        logic eb;
        int own;
        do_reset();
        for (int t = 0; t < 6; t++) begin
            bus1.req = 4'b0011;
            for (int i = 0; i < N; i++) bus1.req_data[i*W +: W] = 8'(8'hC0 + i * 16 + t);
            @(negedge clk);
            eb  = (t % 2 == 1);
            own = ((t - 1) / 2) % 2;
            checks++;
            if (eb) begin
                if ({bus1.busy, bus1.fifo_winc, bus1.owner, bus1.fifo_wdata} !== {1'b1, 1'b1, 2'(own), 8'(8'hC0 + own * 16 + t)}) begin
                    errors++;
                    $display("[TB] FAIL max_burst_one t=%0d busy/winc/owner/wdata got %b/%b/%0d/%h want 1/1/%0d/%h",
                             t, bus1.busy, bus1.fifo_winc, bus1.owner, bus1.fifo_wdata, own, 8'(8'hC0 + own * 16 + t));
                end
            end else if ({bus1.busy, bus1.fifo_winc} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL max_burst_one t=%0d busy/winc got %b/%b want 0/0", t, bus1.busy, bus1.fifo_winc);
            end
            next_cycle();
        end
        bus1.req = '0;
    endtask

    task automatic test_random();
        logic       eb, ew;
        logic [3:0] eg;
        logic [7:0] ed;
        do_reset();
        for (int t = 0; t < 800; t++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) bus.req[i] = ~bus.req[i];
                bus.req_last[i] = ($urandom_range(0, 5) == 0);
            end
            bus.req_data   = $urandom;
            bus.fifo_wfull = ($urandom_range(0, 3) == 0);
            rst            = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            eb = (m_busy != 0);
            eg = eb ? 4'(1 << m_owner) : 4'b0000;
            ew = eb && bus.req[m_owner] && !bus.fifo_wfull;
            ed = eb ? bus.req_data[m_owner*W +: W] : 8'h00;
            checks++;
            if ({bus.busy, bus.gnt, bus.fifo_winc, bus.fifo_wdata} !== {eb, eg, ew, ed}) begin
                errors++;
                $display("[TB] FAIL random t=%0d busy/gnt/winc/wdata got %b/%b/%b/%h want %b/%b/%b/%h",
                         t, bus.busy, bus.gnt, bus.fifo_winc, bus.fifo_wdata, eb, eg, ew, ed);
            end
            if (eb) begin
                checks++;
                if (bus.owner !== 2'(m_owner)) begin
                    errors++;
                    $display("[TB] FAIL random_owner t=%0d got %0d want %0d", t, bus.owner, m_owner);
                end
            end
            next_cycle();
        end
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_round_robin();
        test_burst_limit();
        test_stall();
        test_withdraw();
        test_reset_mid_tenure();
        test_last_stall();
        test_max_burst_one();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got timeout want completion");
        $fatal(1, "[TB] watchdog");
    end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the FIFO write port; power of two, 2..8.
REQ-002 Parameter WIDTH, default 8: data width, equal to the downstream FIFO WIDTH.
REQ-003 Parameter MAX_BURST, default 4: maximum beats per grant tenure, 1..16.
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req  input  NREQ  per-requester write request; bit i holds while requester i has data.
REQ-007 req_data  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
REQ-008 req_last  input  NREQ  bit i marks requester i's current beat as end of packet.
REQ-009 fifo_wfull  input  1  full flag from the downstream FIFO write side.
REQ-010 gnt  output  NREQ  one-hot grant, or all-zero; a beat is accepted when gnt[i] & req[i] & !fifo_wfull.
REQ-011 fifo_winc  output  1  write strobe to the FIFO.
REQ-012 fifo_wdata  output  WIDTH  write data to the FIFO.
REQ-013 owner  output  $clog2(NREQ)  index of the current owner; valid while busy=1.
REQ-014 busy  output  1  high in state OWN.

Function
REQ-015 The FSM SHALL have two states: IDLE and OWN.
REQ-016 In IDLE with any req bit set, the block SHALL pick the first set bit at or after rr_ptr, searching upward with wrap from NREQ-1 to 0.
REQ-017 On that selection the block SHALL load owner, clear beat_cnt and enter OWN on the next edge, giving 1-cycle arbitration latency.
REQ-018 In IDLE with req=0 the block SHALL remain in IDLE.
REQ-019 In IDLE, gnt SHALL be 0 and fifo_winc SHALL be 0.
REQ-020 In OWN, gnt SHALL equal the one-hot of owner, decoded combinationally from registered state.
REQ-021 fifo_winc SHALL equal req[owner] & !fifo_wfull & busy.
REQ-022 fifo_wdata SHALL equal req_data[owner*WIDTH +: WIDTH] whenever busy=1, and 0 otherwise.
REQ-023 beat_cnt SHALL increment by 1 on each accepted beat.
REQ-024 beat_cnt SHALL be $clog2(MAX_BURST)+1 bits wide and SHALL never wrap within a tenure.
REQ-025 Release SHALL occur at the end of a cycle in OWN in which any of these holds: (a) a beat is accepted with req_last[owner]=1; (b) a beat is accepted and beat_cnt = MAX_BURST-1; (c) req[owner]=0 (requester withdrew).
REQ-026 On release the block SHALL set rr_ptr to (owner+1) mod NREQ and return to IDLE, giving a 1-cycle bubble before the next grant.
REQ-027 While fifo_wfull=1 in OWN, there SHALL be no accept and no beat_cnt change.
REQ-028 While fifo_wfull=1 in OWN, owner SHALL be held; a stall alone SHALL never cause release.
REQ-029 A beat with req_last=1 that coincides with fifo_wfull=1 SHALL not cause release until it is accepted.
REQ-030 Requests from non-owners during OWN SHALL be ignored and SHALL not alter state.
REQ-031 With MAX_BURST=1, every accepted beat SHALL cause release.

Reset
REQ-032 While rst=1 at a clock edge, state SHALL become IDLE, with owner=0, rr_ptr=0 and beat_cnt=0.
REQ-033 Immediately after reset, gnt=0, fifo_winc=0, fifo_wdata=0 and busy=0.
REQ-034 Reset asserted mid-tenure SHALL abort the tenure without a further fifo_winc in the cycle following the reset edge.
REQ-035 The first arbitration after reset SHALL start from requester 0.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
- After reset, req=4'b1111 with last only on the 2nd beat of each requester -> grants 0,1,2,3,0 in order; 2 winc per tenure; 1 idle cycle between tenures.
- req[2]=1 only, last never set, MAX_BURST=4 -> exactly 4 consecutive winc with owner=2, release, 1 bubble, then owner=2 again.
- Owner 1 mid-packet, fifo_wfull=1 for 3 cycles -> winc=0 for those 3 cycles, gnt stays 4'b0010, beat_cnt unchanged, transfer resumes with the same data.
- Owner 3 drops req[3] after 1 beat -> release next edge, rr_ptr=0; pending req[0] is granted 2 cycles later.
- rst=1 during owner 2's second beat -> next cycle busy=0, gnt=0, winc=0; the following request from 3 alone is granted as owner 3.
- last=1 coincident with fifo_wfull=1 -> no release until the beat is accepted; exactly one winc for that beat.
